// File: rtl/event_gen_pkg.sv
// Shared types and constants for the event generator: FSM encoding,
// seven-segment patterns and default pulse timing.
package event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int DEFAULT_HIGH_CYCLES = 4;
    localparam int DEFAULT_LOW_CYCLES  = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[v] is digit v.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] seg_of(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_7seg
    import event_gen_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = seg_of(value);

endmodule

// File: rtl/key_edge_sync.sv
// Three-flop synchronizer for one active-low push button; flags the release.
module key_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic release_evt
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], key_n};
    end

    // NOTE: preloading to 1 (released) means a key already up at reset is not
    // mistaken for a fresh release when reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign release_evt = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/event_generator.sv
// Button-triggered pulse-train generator: emits N pulses of HIGH_CYCLES high
// and LOW_CYCLES low, with abort, remaining-count display and running total.
module event_generator
    import event_gen_pkg::*;
#(
    parameter int HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
    parameter int LOW_CYCLES  = DEFAULT_LOW_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic       PULSE_OUT,
    output logic [6:0] HEX0,
    output logic [9:0] LEDR
);

    localparam logic [15:0] HIGH_LAST = 16'(HIGH_CYCLES - 1);
    localparam logic [15:0] LOW_LAST  = 16'(LOW_CYCLES - 1);

    logic start_evt;
    logic abort_evt;
    logic [6:0] seg_value;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [8:0]  total_q, total_d;
    logic        pulse_q, pulse_d;
    logic        busy_q, busy_d;
    logic [6:0]  hex_q, hex_d;

    logic unused_inputs;
    assign unused_inputs = ^{KEY[3:2], SW[9:4]};

    key_edge_sync u_start (
        .clk         (CLOCK_50),
        .reset       (RESET),
        .key_n       (KEY[0]),
        .release_evt (start_evt)
    );

    key_edge_sync u_abort (
        .clk         (CLOCK_50),
        .reset       (RESET),
        .key_n       (KEY[1]),
        .release_evt (abort_evt)
    );

    hex_to_7seg u_hex (
        .value (remaining_q),
        .seg   (seg_value)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        total_d     = total_q;

        // Abort outranks every state transition, including a same-cycle start.
        if (abort_evt) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_evt && (SW[3:0] != 4'd0)) begin
                        state_d     = ST_HIGH;
                        remaining_d = SW[3:0];
                        timer_d     = '0;
                    end
                end
                ST_HIGH: begin
                    if (timer_q == HIGH_LAST) begin
                        state_d     = ST_LOW;
                        remaining_d = remaining_q - 4'd1;
                        total_d     = total_q + 9'd1;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_LOW: begin
                    if (timer_q == LOW_LAST) begin
                        state_d = (remaining_q == 4'd0) ? ST_IDLE : ST_HIGH;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The pulse trails the state by one edge, but an abort drops it at once.
        pulse_d = (state_q == ST_HIGH) && !abort_evt;
        busy_d  = (state_d != ST_IDLE);
        hex_d   = seg_value;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            total_q     <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            hex_q       <= SEG_TABLE[0];
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            total_q     <= total_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            hex_q       <= hex_d;
        end
    end

    assign PULSE_OUT = pulse_q;
    assign HEX0      = hex_q;
    assign LEDR      = {busy_q, total_q};

endmodule

// File: tb/tb_event_generator.sv
// Scoreboard bench for event_generator: each expected pulse (width and total
// after it) is queued when a run is started and checked as the pulse ends.
module tb_event_generator;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic       PULSE_OUT;
    logic [6:0] HEX0;
    logic [9:0] LEDR;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        int         width;
        logic [8:0] total;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [8:0] exp_total = '0;
    int         hi_cnt = 0;

    event_generator #(.HIGH_CYCLES(4), .LOW_CYCLES(4)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .KEY       (KEY),
        .SW        (SW),
        .PULSE_OUT (PULSE_OUT),
        .HEX0      (HEX0),
        .LEDR      (LEDR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [6:0] seg_ref(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Pulse monitor: measures each high run and checks it against the scoreboard.
    always @(negedge CLOCK_50) begin
        if (PULSE_OUT === 1'b1) begin
            hi_cnt++;
        end else if (hi_cnt != 0) begin
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: width %0d, no pulse expected", hi_cnt);
            end else begin
                cur = exp_q.pop_front();
                if (hi_cnt != cur.width) begin
                    failures++;
                    $display("FAIL pulse_width: got %0d, expected %0d", hi_cnt, cur.width);
                end
                assertions++;
                if (LEDR[8:0] !== cur.total) begin
                    failures++;
                    $display("FAIL pulse_total: got %0d, expected %0d", LEDR[8:0], cur.total);
                end
            end
            hi_cnt = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic push_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            exp_total = exp_total + 9'd1;
            exp_q.push_back('{width: 4, total: exp_total});
        end
    endtask

    task automatic release_key(input int idx);
        KEY[idx] = 1'b0;
        tick(4);
        KEY[idx] = 1'b1;
    endtask

    task automatic wait_rise(output int k);
        k = 0;
        while (PULSE_OUT !== 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        if (k >= 40) begin
            failures++;
            $display("FAIL rise_timeout: no pulse within %0d cycles", k);
        end
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (LEDR[9] !== 1'b0 && k < bound) begin
            tick(1);
            k++;
        end
        assertions++;
        if (k >= bound) begin
            failures++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", LEDR[9], k);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(3);
        assertions++;
        if (PULSE_OUT !== 1'b0 || LEDR !== 10'd0 || HEX0 !== seg_ref(0)) begin
            failures++;
            $display("FAIL reset_state: pulse %b ledr %h hex %b, expected 0 000 %b",
                     PULSE_OUT, LEDR, HEX0, seg_ref(0));
        end
        RESET = 1'b0;
        tick(12);
        assertions++;
        if (LEDR[9] !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_event: busy %b, expected 0", LEDR[9]);
        end
    endtask

    task automatic test_zero_count();
        SW = 10'd0;
        release_key(0);
        tick(20);
        assertions++;
        if (LEDR !== 10'd0 || HEX0 !== seg_ref(0) || PULSE_OUT !== 1'b0) begin
            failures++;
            $display("FAIL zero_count: ledr %h hex %b pulse %b, expected 000 %b 0",
                     LEDR, HEX0, PULSE_OUT, seg_ref(0));
        end
    endtask

    task automatic test_basic_run();
        int k;
        int bad = 0;
        logic [6:0] last_hex;
        logic [6:0] hex_seq[$];
        logic exp_pulse;
        SW = 10'd3;
        push_pulses(3);
        release_key(0);
        wait_rise(k);
        assertions++;
        if (k - 1 != 3) begin
            failures++;
            $display("FAIL start_latency: got %0d edges, expected 3", k - 1);
        end
        last_hex = HEX0;
        hex_seq.push_back(HEX0);
        for (int s = 0; s < 30; s++) begin
            if (s > 0) tick(1);
            exp_pulse = (s < 24) && ((s % 8) < 4);
            if (PULSE_OUT !== exp_pulse) bad++;
            if (HEX0 !== last_hex) begin
                hex_seq.push_back(HEX0);
                last_hex = HEX0;
            end
            if (s == 20 || s == 28) begin
                assertions++;
                if (LEDR[9] !== (s == 20)) begin
                    failures++;
                    $display("FAIL busy_window: cycle %0d busy %b, expected %b", s, LEDR[9], s == 20);
                end
            end
        end
        assertions++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pulse_train: %0d cycles differ from 4-high/4-low x3", bad);
        end
        assertions++;
        if (hex_seq.size() != 4 || hex_seq[0] !== seg_ref(3) || hex_seq[1] !== seg_ref(2)
            || hex_seq[2] !== seg_ref(1) || hex_seq[3] !== seg_ref(0)) begin
            failures++;
            $display("FAIL hex_sequence: %0d values, first %b, expected 3,2,1,0 patterns",
                     hex_seq.size(), hex_seq[0]);
        end
        assertions++;
        if (LEDR[8:0] !== exp_total) begin
            failures++;
            $display("FAIL basic_total: got %0d, expected %0d", LEDR[8:0], exp_total);
        end
    endtask

    task automatic test_abort();
        int k;
        SW = 10'd5;
        push_pulses(1);
        exp_q.push_back('{width: 3, total: exp_total});
        KEY[1] = 1'b0;
        release_key(0);
        wait_rise(k);
        tick(8);
        assertions++;
        if (PULSE_OUT !== 1'b1) begin
            failures++;
            $display("FAIL abort_second_rise: pulse %b, expected 1", PULSE_OUT);
        end
        KEY[1] = 1'b1;
        tick(2);
        assertions++;
        if (PULSE_OUT !== 1'b1) begin
            failures++;
            $display("FAIL abort_before_event: pulse %b, expected 1", PULSE_OUT);
        end
        tick(1);
        assertions++;
        if (PULSE_OUT !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop: pulse %b, expected 0", PULSE_OUT);
        end
        tick(2);
        assertions++;
        if (LEDR !== {1'b0, exp_total} || HEX0 !== seg_ref(0)) begin
            failures++;
            $display("FAIL abort_state: ledr %h hex %b, expected %h %b",
                     LEDR, HEX0, {1'b0, exp_total}, seg_ref(0));
        end
        tick(20);
    endtask

    task automatic test_ignore_restart();
        int k;
        SW = 10'd2;
        push_pulses(2);
        release_key(0);
        wait_rise(k);
        SW = 10'd15;
        release_key(0);
        wait_idle(200);
        tick(20);
        assertions++;
        if (LEDR[8:0] !== exp_total || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ignore_restart: total %0d pending %0d, expected %0d 0",
                     LEDR[8:0], exp_q.size(), exp_total);
        end
    endtask

    task automatic test_wrap();
        int k;
        for (int b = 0; b < 34; b++) begin
            SW = 10'd15;
            push_pulses(15);
            release_key(0);
            wait_rise(k);
            wait_idle(300);
        end
        tick(4);
        assertions++;
        if (LEDR[8:0] !== exp_total) begin
            failures++;
            $display("FAIL wrap_total: got %0d, expected %0d", LEDR[8:0], exp_total);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int k;
        SW = 10'd3;
        exp_total = '0;
        exp_q.push_back('{width: 2, total: 9'd0});
        release_key(0);
        wait_rise(k);
        tick(1);
        RESET = 1'b1;
        tick(1);
        assertions++;
        if (PULSE_OUT !== 1'b0 || LEDR !== 10'd0 || HEX0 !== seg_ref(0)) begin
            failures++;
            $display("FAIL reset_mid_pulse: pulse %b ledr %h hex %b, expected 0 000 %b",
                     PULSE_OUT, LEDR, HEX0, seg_ref(0));
        end
        tick(2);
        RESET = 1'b0;
        tick(20);
        assertions++;
        if (LEDR !== 10'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_quiet: ledr %h pending %0d, expected 000 0", LEDR, exp_q.size());
        end
    endtask

    initial begin
        RESET = 1'b1;
        KEY   = 4'hF;
        SW    = 10'd0;
        test_reset();
        test_zero_count();
        test_basic_run();
        test_abort();
        test_ignore_restart();
        test_wrap();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
